memory_arbiter: RTL

Arbitrates the request unit's instruction-fetch and data-access requests onto a single shared RAM port with a request/acknowledge handshake. Sits directly downstream of the request unit. It consumes iren/dren/wren, the addresses and the store data, and returns ihit/dhit with load data. It holds one access in flight at a time and keeps address, write-enable and store data stable until the RAM acknowledges.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/ram_model.sv | 70 +++++++
 rtl/memory_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and default widths for the memory arbiter and its RAM model.
package mem_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    // Which requester owns the access in flight.
    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } src_t;

endpackage

// File: rtl/ram_model.sv
// Word-addressed RAM with a request/acknowledge port and a configurable ack
// delay (0 = ack registered on the first request cycle). ack and rdata are
// registered. A separate preload port writes the array directly.
module ram_model
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = 6,
    parameter int DLY_W  = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [DLY_W-1:0]  ack_delay,
    input  logic              ram_req,
    input  logic              ram_wen,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] ram_rdata,
    output logic              ram_ack,
    input  logic              pl_en,
    input  logic [ADDR_W-1:0] pl_addr,
    input  logic [DATA_W-1:0] pl_data
);

    localparam int              DEPTH   = 1 << IDX_W;
    localparam logic [DLY_W-1:0] DLY_ONE = DLY_W'(1);

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DLY_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  pl_idx;
    logic              ack_fire;
    logic              unused_addr_bits;

    assign idx      = ram_addr[IDX_W+1:2];
    assign pl_idx   = pl_addr[IDX_W+1:2];
    assign ack_fire = ram_req && !ram_ack && (cnt == ack_delay);
    assign unused_addr_bits = ^{ram_addr[ADDR_W-1:IDX_W+2], ram_addr[1:0],
                                pl_addr[ADDR_W-1:IDX_W+2], pl_addr[1:0]};

    // Delay counter, registered ack pulse and read data.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt       <= '0;
            ram_ack   <= 1'b0;
            ram_rdata <= '0;
        end else begin
            ram_ack <= ack_fire;
            if (!ram_req || ram_ack || ack_fire) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DLY_ONE;
            end
            if (ack_fire) begin
                ram_rdata <= ram_wen ? ram_wdata : mem[idx];
            end
        end
    end

    // Storage array: preload has priority over a completing write.
    always_ff @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (ack_fire && ram_wen) begin
            mem[idx] <= ram_wdata;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one shared RAM port.
// One access is in flight at a time. Data wins over instruction when both
// are requested in the same IDLE cycle.
//
// RAM handshake: ram_req is held high with ram_addr/ram_wen/ram_wdata stable
// (driven only from latched registers) until a one-cycle ram_ack. ram_rdata
// is sampled in the ack cycle. ram_ack seen outside IACC/DACC is ignored.
// Every output is decoded from state plus registers; no input reaches an
// output combinationally.
module memory_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              iren,
    input  logic              dren,
    input  logic              wren,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              ihit,
    output logic              dhit,
    output logic [DATA_W-1:0] iload,
    output logic [DATA_W-1:0] dload,
    output logic              ram_req,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack,
    output arb_state_t        dbg_state
);

    arb_state_t        state;
    arb_state_t        next_state;
    src_t              src_q;
    logic              kill_q;
    logic              wen_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] load_q;
    logic              data_en;

    assign data_en = dren | wren;

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        next_state = state;
        ram_req    = 1'b0;
        ihit       = 1'b0;
        dhit       = 1'b0;
        case (state)
            IDLE: begin
                if (data_en) begin
                    next_state = DACC;
                end else if (iren) begin
                    next_state = IACC;
                end
            end
            IACC, DACC: begin
                ram_req = 1'b1;
                if (ram_ack) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                // The next grant waits for IDLE so a request still held in the
                // hit cycle cannot launch a duplicate access.
                ihit       = (src_q == INSTR) && !kill_q;
                dhit       = (src_q == DATA) && !kill_q;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Access registers: latched on grant, load captured on ack, kill tracks
    // an originating enable that drops while the access is pending.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            src_q   <= INSTR;
            kill_q  <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            load_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    kill_q <= 1'b0;
                    if (data_en) begin
                        addr_q  <= daddr;
                        wen_q   <= wren;
                        wdata_q <= dstore;
                        src_q   <= DATA;
                    end else if (iren) begin
                        addr_q <= iaddr;
                        wen_q  <= 1'b0;
                        src_q  <= INSTR;
                    end
                end
                IACC: begin
                    if (!iren) begin
                        kill_q <= 1'b1;
                    end
                    if (ram_ack) begin
                        load_q <= ram_rdata;
                    end
                end
                DACC: begin
                    if (!data_en) begin
                        kill_q <= 1'b1;
                    end
                    if (ram_ack) begin
                        load_q <= ram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ram_wen   = ram_req & wen_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign iload     = load_q;
    assign dload     = load_q;
    assign dbg_state = state;

endmodule
